// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexes an N-digit hex value onto a single
// 7-segment decoder input, one digit slot at a time, with per-slot dead time
// and optional leading-zero blanking. The shown value only changes at frame
// boundaries, so a frame never mixes digits from two different values.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_in    4*NUM_DIGITS hex value, digit 0 in the low nibble
//   load       capture data_in into the shadow register at this edge
//   lzb_en     blank leading zero digits (digit 0 is never blanked)
//   nibble     nibble of the current digit, to the decoder input
//   digit_en   one-hot active-high digit enable, all zero = dark
//   digit_idx  index of the current slot's digit
//   frame_tick one-cycle pulse at the start of each frame
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    lzb_en,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned SW = $clog2(REFRESH_DIV);

  logic [DW-1:0]         shadow, shadow_nxt;
  logic [DW-1:0]         disp, disp_nxt;
  logic [SW-1:0]         slot_cnt, slot_nxt;
  logic [2:0]            idx_nxt;
  logic                  started;
  logic                  frame_nxt;
  logic [3:0]            nib_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic                  upper_zero;

  // Next-state and next-output computation; outputs are registered from the
  // next-state values so they line up with the internal counters each cycle.
  always_comb begin
    slot_nxt   = slot_cnt;
    idx_nxt    = digit_idx;
    shadow_nxt = shadow;
    disp_nxt   = disp;
    nib_nxt    = 4'h0;
    en_nxt     = '0;
    blank      = '0;
    upper_zero = 1'b1;

    // The first edge after reset presents t=0 rather than advancing past it.
    if (!started) begin
      slot_nxt = '0;
      idx_nxt  = 3'd0;
    end else if (slot_cnt == SW'(REFRESH_DIV - 1)) begin
      slot_nxt = '0;
      idx_nxt  = (digit_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      slot_nxt = slot_cnt + SW'(1);
    end

    frame_nxt = (slot_nxt == '0) && (idx_nxt == 3'd0);

    if (load) shadow_nxt = data_in;

    // Commit at the frame boundary; a coincident load bypasses the shadow.
    if (frame_nxt) disp_nxt = load ? data_in : shadow;

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_nxt == 3'(i)) nib_nxt = disp_nxt[4*i +: 4];
    end

    // Walk from the top digit down; a digit is blanked while everything at
    // and above it is zero.
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_nxt[4*i +: 4] == 4'h0);
      blank[i]   = lzb_en && upper_zero && (i != 0);
    end

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      en_nxt[i] = (idx_nxt == 3'(i)) &&
                  (int'(slot_nxt) >= int'(DEAD_CYCLES)) &&
                  !blank[i];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      disp       <= '0;
      slot_cnt   <= '0;
      digit_idx  <= 3'd0;
      started    <= 1'b0;
      nibble     <= 4'h0;
      digit_en   <= '0;
      frame_tick <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      disp       <= disp_nxt;
      slot_cnt   <= slot_nxt;
      digit_idx  <= idx_nxt;
      started    <= 1'b1;
      nibble     <= nib_nxt;
      digit_en   <= en_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: a 4-digit instance (REFRESH_DIV=8,
// DEAD_CYCLES=2) and a 1-digit instance (REFRESH_DIV=4, DEAD_CYCLES=0).
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        rst, load, lzb_en;
  logic [15:0] data_in;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  // 1-digit instance
  logic        rst1, load1, lzb1;
  logic [3:0]  data1;
  logic [3:0]  nib1;
  logic [0:0]  en1;
  logic [2:0]  idx1;
  logic        ft1;

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .lzb_en(lzb_en),
    .nibble(nibble), .digit_en(digit_en), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  hex_display_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst1), .data_in(data1), .load(load1), .lzb_en(lzb1),
    .nibble(nib1), .digit_en(en1), .digit_idx(idx1), .frame_tick(ft1)
  );

  typedef struct {
    int         t;
    logic [3:0] nib;
    logic [3:0] en;
    logic       ft;
    logic [2:0] idx;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic chk(input string name, input logic [3:0] nib_e,
                     input logic [3:0] en_e, input logic ft_e,
                     input logic [2:0] idx_e);
    total++;
    if (nibble !== nib_e || digit_en !== en_e || frame_tick !== ft_e ||
        digit_idx !== idx_e) begin
      bad++;
      $display("FAIL %s t=%0d got nib=%h en=%b ft=%b idx=%0d want nib=%h en=%b ft=%b idx=%0d",
               name, t, nibble, digit_en, frame_tick, digit_idx,
               nib_e, en_e, ft_e, idx_e);
    end
  endtask

  // Advance one edge and sample #1 later; every cycle checks the one-hot rule.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    total++;
    if ($countones(digit_en) > 1) begin
      bad++;
      $display("FAIL onehot t=%0d got en=%b want at most one bit", t, digit_en);
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  // Two reset edges; the next tick after this is t=0.
  task automatic do_reset();
    rst = 1'b1; load = 1'b0; lzb_en = 1'b0; data_in = 16'h0;
    tick();
    tick();
    chk("reset", 4'h0, 4'b0000, 1'b0, 3'd0);
    rst = 1'b0;
    t = -1;
  endtask

  task automatic start_with(input logic [15:0] v);
    do_reset();
    load = 1'b1; data_in = v;
    tick();
    load = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d got no finish want finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,  4'hF, 4'b0000, 1'b1, 3'd0};
    vecs[1]  = '{1,  4'hF, 4'b0000, 1'b0, 3'd0};
    vecs[2]  = '{2,  4'hF, 4'b0001, 1'b0, 3'd0};
    vecs[3]  = '{7,  4'hF, 4'b0001, 1'b0, 3'd0};
    vecs[4]  = '{8,  4'h2, 4'b0000, 1'b0, 3'd1};
    vecs[5]  = '{9,  4'h2, 4'b0000, 1'b0, 3'd1};
    vecs[6]  = '{10, 4'h2, 4'b0010, 1'b0, 3'd1};
    vecs[7]  = '{15, 4'h2, 4'b0010, 1'b0, 3'd1};
    vecs[8]  = '{16, 4'hA, 4'b0000, 1'b0, 3'd2};
    vecs[9]  = '{18, 4'hA, 4'b0100, 1'b0, 3'd2};
    vecs[10] = '{24, 4'h1, 4'b0000, 1'b0, 3'd3};
    vecs[11] = '{26, 4'h1, 4'b1000, 1'b0, 3'd3};
    vecs[12] = '{31, 4'h1, 4'b1000, 1'b0, 3'd3};
    vecs[13] = '{32, 4'hF, 4'b0000, 1'b1, 3'd0};
    vecs[14] = '{64, 4'hF, 4'b0000, 1'b1, 3'd0};

    rst1 = 1'b1; load1 = 1'b0; lzb1 = 1'b0; data1 = 4'h0;

    // Basic scan of 1A2F, committed by bypass at t=0.
    start_with(16'h1A2F);
    for (int i = 0; i < 15; i++) begin
      run_to(vecs[i].t);
      chk("scan", vecs[i].nib, vecs[i].en, vecs[i].ft, vecs[i].idx);
    end

    // Mid-frame load only shows from the next frame.
    start_with(16'h1A2F);
    run_to(4);
    load = 1'b1; data_in = 16'h5555;
    tick();
    load = 1'b0;
    run_to(24); chk("midload_old", 4'h1, 4'b0000, 1'b0, 3'd3);
    run_to(31); chk("midload_last", 4'h1, 4'b1000, 1'b0, 3'd3);
    run_to(32); chk("midload_new", 4'h5, 4'b0000, 1'b1, 3'd0);
    run_to(34); chk("midload_d0", 4'h5, 4'b0001, 1'b0, 3'd0);
    run_to(42); chk("midload_d1", 4'h5, 4'b0010, 1'b0, 3'd1);

    // Leading-zero blanking.
    do_reset();
    lzb_en = 1'b1; load = 1'b1; data_in = 16'h0030;
    tick();
    load = 1'b0;
    run_to(2);  chk("lzb_d0", 4'h0, 4'b0001, 1'b0, 3'd0);
    run_to(10); chk("lzb_d1", 4'h3, 4'b0010, 1'b0, 3'd1);
    run_to(18); chk("lzb_d2", 4'h0, 4'b0000, 1'b0, 3'd2);
    run_to(19);
    load = 1'b1; data_in = 16'h0000;
    tick();
    load = 1'b0;
    run_to(26); chk("lzb_d3", 4'h0, 4'b0000, 1'b0, 3'd3);
    run_to(34); chk("lzb0_d0", 4'h0, 4'b0001, 1'b0, 3'd0);
    run_to(42); chk("lzb0_d1", 4'h0, 4'b0000, 1'b0, 3'd1);
    run_to(50); chk("lzb0_d2", 4'h0, 4'b0000, 1'b0, 3'd2);
    lzb_en = 1'b0;
    tick();
    chk("lzb_off", 4'h0, 4'b0100, 1'b0, 3'd2);

    // Reset in the middle of a frame.
    start_with(16'h1A2F);
    run_to(12);
    rst = 1'b1;
    tick();
    chk("midrst", 4'h0, 4'b0000, 1'b0, 3'd0);
    rst = 1'b0;
    t = -1;
    tick();
    chk("midrst_restart", 4'h0, 4'b0000, 1'b1, 3'd0);
    run_to(2);  chk("midrst_d0", 4'h0, 4'b0001, 1'b0, 3'd0);
    run_to(10); chk("midrst_d1", 4'h0, 4'b0010, 1'b0, 3'd1);

    // Back-to-back loads, then a load on the frame edge itself.
    start_with(16'h1A2F);
    run_to(29);
    load = 1'b1; data_in = 16'h1111;
    tick();
    data_in = 16'h2222;
    tick();
    load = 1'b0;
    chk("b2b_before", 4'h1, 4'b1000, 1'b0, 3'd3);
    tick();
    chk("b2b_frame", 4'h2, 4'b0000, 1'b1, 3'd0);
    run_to(34); chk("b2b_d0", 4'h2, 4'b0001, 1'b0, 3'd0);
    run_to(49);
    load = 1'b1; data_in = 16'h1111;
    tick();
    load = 1'b0;
    run_to(63); chk("bypass_before", 4'h2, 4'b1000, 1'b0, 3'd3);
    load = 1'b1; data_in = 16'h7777;
    tick();
    load = 1'b0;
    chk("bypass_frame", 4'h7, 4'b0000, 1'b1, 3'd0);

    // Single-digit instance: always lit, frame every 4 cycles.
    rst1 = 1'b1;
    tick();
    total++;
    if (en1 !== 1'b0 || ft1 !== 1'b0 || nib1 !== 4'h0) begin
      bad++;
      $display("FAIL one_reset got nib=%h en=%b ft=%b want 0 0 0", nib1, en1, ft1);
    end
    rst1 = 1'b0; load1 = 1'b1; data1 = 4'h9;
    tick();
    load1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total++;
      if (en1 !== 1'b1 || ft1 !== ((k % 4) == 0) || idx1 !== 3'd0 || nib1 !== 4'h9) begin
        bad++;
        $display("FAIL one_digit k=%0d got nib=%h en=%b ft=%b idx=%0d want nib=9 en=1 ft=%0d idx=0",
                 k, nib1, en1, ft1, idx1, ((k % 4) == 0));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
